// File: rtl/muldiv_seq_pkg.sv
// Shared opcodes, funct3 constants and FSM states for the multiply/divide sequencer.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_t;

    localparam logic [2:0] MD_MUL  = 3'b000;
    localparam logic [2:0] MD_DIV  = 3'b100;
    localparam logic [2:0] MD_DIVU = 3'b101;
    localparam logic [2:0] MD_REM  = 3'b110;
    localparam logic [2:0] MD_REMU = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_NEG,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Private 32-bit combinational ALU used by the sequencer for add/subtract steps.
module muldiv_seq_alu
    import muldiv_seq_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M MUL/DIV/DIVU/REM/REMU sequencer: 32 shift-add / restoring-divide steps through one ALU.
// Signed DIV/REM (NEG/FIX states) only exist when MULDIV_SIGNED_EN is defined.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] Op_A,
    input  logic [31:0] Op_B,
    output logic        Busy,
    output logic        Valid,
    output logic        Illegal,
    output logic [31:0] Result
);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    md_state_t   state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic        illegal_q, illegal_d;

    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_y;

    logic        accept, dec_illegal, dec_div, dec_signed, dec_dz, dec_rem;
    logic        is_rem_q, fix_neg;
    logic [31:0] fix_val, rem_next, quo_next;
    logic [32:0] div_t;
    logic        div_ge;

    muldiv_seq_alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign accept   = Start && (state_q == MD_IDLE || state_q == MD_DONE);
    assign is_rem_q = (op_q == MD_REM) || (op_q == MD_REMU);
    assign dec_rem  = (Op == MD_REM) || (Op == MD_REMU);
    assign dec_dz   = dec_div && (Op_B == '0);

    // Restoring step: the 33-bit compare is local, the ALU subtract only sees the low word.
    assign div_t    = {acc_q, mplier_q[31]};
    assign div_ge   = div_t >= {1'b0, mcand_q};
    assign rem_next = div_ge ? alu_y : div_t[31:0];
    assign quo_next = {mplier_q[30:0], div_ge};

    assign fix_neg  = is_rem_q ? sign_a_q : (sign_a_q ^ sign_b_q);
    assign fix_val  = is_rem_q ? acc_q : mplier_q;

    always_comb begin
        dec_illegal = 1'b0;
        dec_div     = 1'b0;
        dec_signed  = 1'b0;
        case (Op)
            MD_MUL: ;
            MD_DIVU, MD_REMU: dec_div = 1'b1;
            MD_DIV, MD_REM: begin
                dec_div     = SIGNED_EN;
                dec_signed  = SIGNED_EN;
                dec_illegal = !SIGNED_EN;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (state_q == MD_DONE) state_d = MD_IDLE;
                if (accept) begin
                    if (dec_illegal || dec_dz)      state_d = MD_DONE;
                    else if (dec_div && SIGNED_EN)  state_d = MD_NEG;
                    else                            state_d = MD_RUN;
                end
            end
            MD_NEG: if (cnt_q[0]) state_d = MD_RUN;
            MD_RUN: if (cnt_q == 5'd31)
                        state_d = (SIGNED_EN && op_q != MD_MUL) ? MD_FIX : MD_DONE;
            MD_FIX:  state_d = MD_DONE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        illegal_d = illegal_q;
        alu_op    = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (accept) begin
                    op_d     = Op;
                    cnt_d    = '0;
                    acc_d    = '0;
                    sign_a_d = dec_signed && Op_A[31];
                    sign_b_d = dec_signed && Op_B[31];
                    mcand_d  = (Op == MD_MUL) ? Op_A : Op_B;
                    mplier_d = (Op == MD_MUL) ? Op_B : Op_A;
                    if (dec_illegal) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end else if (dec_dz) begin
                        result_d  = dec_rem ? Op_A : '1;
                        illegal_d = 1'b0;
                    end
                end
            end
            MD_NEG: begin
                cnt_d = cnt_q[0] ? 5'd0 : 5'd1;
                if (!cnt_q[0] && sign_a_q) begin
                    alu_op   = ALU_SUB;
                    alu_b    = mplier_q;
                    mplier_d = alu_y;
                end else if (cnt_q[0] && sign_b_q) begin
                    alu_op  = ALU_SUB;
                    alu_b   = mcand_q;
                    mcand_d = alu_y;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q == MD_MUL) begin
                    if (mplier_q[0]) begin
                        alu_a = acc_q;
                        alu_b = mcand_q;
                        acc_d = alu_y;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == 5'd31) begin
                        result_d  = acc_d;
                        illegal_d = 1'b0;
                    end
                end else begin
                    if (div_ge) begin
                        alu_op = ALU_SUB;
                        alu_a  = div_t[31:0];
                        alu_b  = mcand_q;
                    end
                    acc_d    = rem_next;
                    mplier_d = quo_next;
                    if (cnt_q == 5'd31 && !SIGNED_EN) begin
                        result_d  = is_rem_q ? rem_next : quo_next;
                        illegal_d = 1'b0;
                    end
                end
            end
            MD_FIX: begin
                if (fix_neg) begin
                    alu_op = ALU_SUB;
                    alu_b  = fix_val;
                end
                result_d  = fix_neg ? alu_y : fix_val;
                illegal_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy    = (state_q == MD_NEG) || (state_q == MD_RUN) || (state_q == MD_FIX);
        Valid   = (state_q == MD_DONE);
        Illegal = illegal_q;
        Result  = result_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, illegal ops, Start drop, back-to-back, mid-op reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

`ifdef MULDIV_SIGNED_EN
    localparam int DIV_LAT = 36;
`else
    localparam int DIV_LAT = 33;
`endif

    logic        clk, rst, Start;
    logic [2:0]  Op;
    logic [31:0] Op_A, Op_B;
    logic        Busy, Valid, Illegal;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Op      (Op),
        .Op_A    (Op_A),
        .Op_B    (Op_B),
        .Busy    (Busy),
        .Valid   (Valid),
        .Illegal (Illegal),
        .Result  (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op and returns the cycle (counting the accept cycle as 0) at which Valid is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic ill);
        @(negedge clk);
        Start = 1'b1; Op = op; Op_A = a; Op_B = b;
        @(posedge clk);
        #1 Start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (Valid) begin
                lat = c;
                break;
            end
        end
        res = Result;
        ill = Illegal;
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Op = '0; Op_A = '0; Op_B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy); end
        vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", Valid); end
        vectors++; if (Illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b want 0", Illegal); end
        vectors++; if (Result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", Result); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat; logic [31:0] r; logic il;
        run_op(MD_MUL, 32'd7, 32'd6, lat, r, il);
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL mul7x6_lat got %0d want 33", lat); end
        vectors++; if (r !== 32'd42) begin miscompares++; $display("FAIL mul7x6 got %h want 0000002a", r); end
        vectors++; if (il !== 1'b0) begin miscompares++; $display("FAIL mul7x6_illegal got %b want 0", il); end
        run_op(MD_MUL, 32'hFFFF_FFFF, 32'd2, lat, r, il);
        vectors++; if (r !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mul_m1x2 got %h want fffffffe", r); end
        run_op(MD_MUL, 32'h1234_5678, 32'h10, lat, r, il);
        vectors++; if (r !== 32'h2345_6780) begin miscompares++; $display("FAIL mul_shift got %h want 23456780", r); end
    endtask

    task automatic test_divu();
        int lat; logic [31:0] r; logic il;
        run_op(MD_DIVU, 32'd100, 32'd7, lat, r, il);
        vectors++; if (lat != DIV_LAT) begin miscompares++; $display("FAIL divu_lat got %0d want %0d", lat, DIV_LAT); end
        vectors++; if (r !== 32'd14) begin miscompares++; $display("FAIL divu100_7 got %h want 0000000e", r); end
        run_op(MD_REMU, 32'd100, 32'd7, lat, r, il);
        vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL remu100_7 got %h want 00000002", r); end
        run_op(MD_DIVU, 32'd5, 32'd0, lat, r, il);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL divu_dz_lat got %0d want 1", lat); end
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu5_0 got %h want ffffffff", r); end
        vectors++; if (il !== 1'b0) begin miscompares++; $display("FAIL divu_dz_illegal got %b want 0", il); end
        run_op(MD_REMU, 32'd5, 32'd0, lat, r, il);
        vectors++; if (r !== 32'd5) begin miscompares++; $display("FAIL remu5_0 got %h want 00000005", r); end
    endtask

    task automatic test_signed();
        int lat; logic [31:0] r; logic il;
`ifdef MULDIV_SIGNED_EN
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, r, il);
        vectors++; if (lat != 36) begin miscompares++; $display("FAIL div_lat got %0d want 36", lat); end
        vectors++; if (r !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
        run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, lat, r, il);
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, il);
        vectors++; if (lat != 36) begin miscompares++; $display("FAIL div_ovf_lat got %0d want 36", lat); end
        vectors++; if (r !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf got %h want 80000000", r); end
        run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, il);
        vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rem_ovf got %h want 00000000", r); end
`else
        run_op(MD_DIV, 32'd8, 32'd2, lat, r, il);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL div_unsup_lat got %0d want 1", lat); end
        vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL div_unsup_illegal got %b want 1", il); end
        vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL div_unsup_result got %h want 0", r); end
        run_op(MD_REM, 32'd8, 32'd3, lat, r, il);
        vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL rem_unsup_illegal got %b want 1", il); end
`endif
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] r; logic il;
        run_op(3'b001, 32'd3, 32'd4, lat, r, il);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL mulh_lat got %0d want 1", lat); end
        vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL mulh_illegal got %b want 1", il); end
        vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL mulh_result got %h want 0", r); end
    endtask

    task automatic test_busy_ignore();
        int lat; int extra; logic [31:0] r;
        @(negedge clk);
        Start = 1'b1; Op = MD_MUL; Op_A = 32'd3; Op_B = 32'd5;
        @(posedge clk);
        #1 Start = 1'b0;
        lat = -1; r = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 10) begin
                vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL busy_mid got %b want 1", Busy); end
                Start = 1'b1; Op_A = 32'd9; Op_B = 32'd9;
            end else begin
                Start = 1'b0;
            end
            if (Valid) begin
                lat = c; r = Result;
                break;
            end
        end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL ignore_lat got %0d want 33", lat); end
        vectors++; if (r !== 32'd15) begin miscompares++; $display("FAIL ignore_result got %h want 0000000f", r); end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Valid) extra++;
        end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL ignore_extra_valid got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        @(negedge clk);
        Start = 1'b1; Op = MD_MUL; Op_A = 32'd2; Op_B = 32'd3;
        @(posedge clk);
        #1 Op_A = 32'd4; Op_B = 32'd5;
        lat1 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (Valid) begin lat1 = c; break; end
        end
        vectors++; if (lat1 != 33) begin miscompares++; $display("FAIL b2b_first_lat got %0d want 33", lat1); end
        vectors++; if (Result !== 32'd6) begin miscompares++; $display("FAIL b2b_first got %h want 00000006", Result); end
        @(posedge clk);
        #1 Start = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", Busy); end
            end
            if (c == 17) begin
                vectors++; if (Result !== 32'd6) begin miscompares++; $display("FAIL b2b_hold got %h want 00000006", Result); end
            end
            if (Valid) begin lat2 = c; break; end
        end
        vectors++; if (lat2 != 33) begin miscompares++; $display("FAIL b2b_second_lat got %0d want 33", lat2); end
        vectors++; if (Result !== 32'd20) begin miscompares++; $display("FAIL b2b_second got %h want 00000014", Result); end
    endtask

    task automatic test_reset_mid();
        int lat; int stray; logic [31:0] r; logic il;
        @(negedge clk);
        Start = 1'b1; Op = MD_DIVU; Op_A = 32'd1000; Op_B = 32'd3;
        @(posedge clk);
        #1 Start = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", Busy); end
        vectors++; if (Valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", Valid); end
        vectors++; if (Illegal !== 1'b0) begin miscompares++; $display("FAIL rstmid_illegal got %b want 0", Illegal); end
        vectors++; if (Result !== 32'h0) begin miscompares++; $display("FAIL rstmid_result got %h want 0", Result); end
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Valid) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL rstmid_stray_valid got %0d want 0", stray); end
        run_op(MD_DIVU, 32'd1000, 32'd3, lat, r, il);
        vectors++; if (lat != DIV_LAT) begin miscompares++; $display("FAIL rstmid_lat got %0d want %0d", lat, DIV_LAT); end
        vectors++; if (r !== 32'd333) begin miscompares++; $display("FAIL rstmid_divu got %h want 0000014d", r); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divu();
        test_signed();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
